// File: rtl/furv_pkg.sv
// Shared constants for the furv pipeline: writeback selects, access widths, mem-stage states.
package furv_pkg;

  localparam logic [1:0] WB_MEM   = 2'd0;
  localparam logic [1:0] WB_PC    = 2'd1;
  localparam logic [1:0] WB_ALU   = 2'd2;
  localparam logic [1:0] WB_SHIFT = 2'd3;

  localparam logic [1:0] MW_BYTE = 2'd0;
  localparam logic [1:0] MW_HALF = 2'd1;
  localparam logic [1:0] MW_WORD = 2'd2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUS  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/furv_mem_lane.sv
// Byte-lane steering for data bus accesses; width 3 behaves as a word access.
module furv_mem_lane
  import furv_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_data,
  output logic [3:0]  o_sel,
  output logic [31:0] o_dat,
  output logic        o_misaligned
);

  always_comb begin
    o_sel        = 4'hF;
    o_dat        = i_data;
    o_misaligned = 1'b0;
    case (i_width)
      MW_BYTE: begin
        o_sel = 4'b0001 << i_addr;
        o_dat = {4{i_data[7:0]}};
      end
      MW_HALF: begin
        o_sel        = 4'b0011 << {i_addr[1], 1'b0};
        o_dat        = {2{i_data[15:0]}};
        o_misaligned = i_addr[0];
      end
      default: begin
        o_misaligned = (i_addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/furv_mem.sv
// furv memory stage: data bus strobe/ack handshake and context registers for writeback.
// Optional FURV_MEM_MISALIGN_TRAP_EN suppresses misaligned half/word accesses and flags them.
module furv_mem
  import furv_pkg::*;
#(
  parameter int DBUS_AW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               stall_o,
  input  logic               mem_i,
  input  logic               mem_we_i,
  input  logic [1:0]         mem_width_i,
  input  logic               mem_unsigned_i,
  input  logic [31:0]        alu_results_i,
  input  logic [31:0]        store_data_i,
  input  logic [31:0]        shifter_results_i,
  input  logic [31:0]        adjacent_pc_i,
  input  logic               reverse_wb_i,
  input  logic [1:0]         wb_sel_i,
  input  logic [4:0]         rd_i,
  output logic [4:0]         rd,
  output logic [1:0]         wb_sel,
  output logic [1:0]         mem_width,
  output logic               mem_unsigned,
  output logic [31:0]        alu_results,
  output logic [31:0]        shifter_results,
  output logic [31:0]        adjacent_pc,
  output logic               reverse_wb,
  output logic               mem,
  output logic [1:0]         byte_addr,
  output logic [31:0]        data_in,
  output logic               mem_ack,
  output logic               valid_o,
  input  logic               stall_i,
  output logic               dbus_stb,
  output logic               dbus_we,
  output logic [DBUS_AW-3:0] dbus_adr,
  output logic [3:0]         dbus_sel,
  output logic [31:0]        dbus_dat_o,
  input  logic               dbus_ack,
  input  logic [31:0]        dbus_dat_i
`ifdef FURV_MEM_MISALIGN_TRAP_EN
  ,
  output logic               misalign_o
`endif
);

`ifdef FURV_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t              r_state;
  logic                r_valid;
  logic                r_stb;
  logic                r_we;
  logic [DBUS_AW-3:0]  r_adr;
  logic [3:0]          r_sel;
  logic [31:0]         r_dat_o;
  logic [31:0]         r_data_in;
  logic [4:0]          r_rd;
  logic [1:0]          r_wb_sel;
  logic [1:0]          r_mem_width;
  logic                r_mem_unsigned;
  logic [31:0]         r_alu;
  logic [31:0]         r_shift;
  logic [31:0]         r_pc4;
  logic                r_reverse_wb;
  logic                r_mem;
  logic [1:0]          r_byte_addr;

  logic [3:0]          w_sel;
  logic [31:0]         w_dat;
  logic                w_misaligned;
  logic                w_trap;

  furv_mem_lane u_lane (
    .i_width      (mem_width_i),
    .i_addr       (alu_results_i[1:0]),
    .i_data       (store_data_i),
    .o_sel        (w_sel),
    .o_dat        (w_dat),
    .o_misaligned (w_misaligned)
  );

  assign w_trap = TRAP_EN & mem_i & w_misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_valid        <= 1'b0;
      r_stb          <= 1'b0;
      r_we           <= 1'b0;
      r_adr          <= '0;
      r_sel          <= '0;
      r_dat_o        <= '0;
      r_data_in      <= '0;
      r_rd           <= '0;
      r_wb_sel       <= '0;
      r_mem_width    <= '0;
      r_mem_unsigned <= 1'b0;
      r_alu          <= '0;
      r_shift        <= '0;
      r_pc4          <= '0;
      r_reverse_wb   <= 1'b0;
      r_mem          <= 1'b0;
      r_byte_addr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!stall_i) begin
            if (valid_i) begin
              r_rd           <= w_trap ? 5'd0 : rd_i;
              r_wb_sel       <= wb_sel_i;
              r_mem_width    <= mem_width_i;
              r_mem_unsigned <= mem_unsigned_i;
              r_alu          <= alu_results_i;
              r_shift        <= shifter_results_i;
              r_pc4          <= adjacent_pc_i;
              r_reverse_wb   <= reverse_wb_i;
              r_mem          <= mem_i;
              r_byte_addr    <= alu_results_i[1:0];
              if (mem_i && !w_trap) begin
                r_valid <= 1'b0;
                r_stb   <= 1'b1;
                r_we    <= mem_we_i;
                r_adr   <= alu_results_i[DBUS_AW-1:2];
                r_sel   <= w_sel;
                r_dat_o <= w_dat;
                r_state <= ST_BUS;
              end else begin
                r_valid <= 1'b1;
              end
            end else begin
              r_valid <= 1'b0;
            end
          end
        end
        ST_BUS: begin
          // Load data is latched on ack even under stall; only valid_o waits for WB.
          if (dbus_ack) begin
            r_data_in <= dbus_dat_i;
            r_stb     <= 1'b0;
            if (stall_i) begin
              r_state <= ST_HOLD;
            end else begin
              r_valid <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FURV_MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk) begin
    if (rst)
      r_misalign <= 1'b0;
    else if (r_state == ST_IDLE && !stall_i && valid_i)
      r_misalign <= w_trap;
  end
  assign misalign_o = r_misalign;
`endif

  assign stall_o         = stall_i | (r_state != ST_IDLE);
  assign mem_ack         = (r_state != ST_BUS);
  assign valid_o         = r_valid;
  assign dbus_stb        = r_stb;
  assign dbus_we         = r_we;
  assign dbus_adr        = r_adr;
  assign dbus_sel        = r_sel;
  assign dbus_dat_o      = r_dat_o;
  assign data_in         = r_data_in;
  assign rd              = r_rd;
  assign wb_sel          = r_wb_sel;
  assign mem_width       = r_mem_width;
  assign mem_unsigned    = r_mem_unsigned;
  assign alu_results     = r_alu;
  assign shifter_results = r_shift;
  assign adjacent_pc     = r_pc4;
  assign reverse_wb      = r_reverse_wb;
  assign mem             = r_mem;
  assign byte_addr       = r_byte_addr;

endmodule

// File: tb/tb_furv_mem.sv
// Directed bench for furv_mem: ALU pass-through, store/load handshakes, WB stall, reset in BUS.
module tb_furv_mem;
  import furv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_o, mem_i, mem_we_i, mem_unsigned_i, reverse_wb_i;
  logic [1:0]  mem_width_i, wb_sel_i;
  logic [31:0] alu_results_i, store_data_i, shifter_results_i, adjacent_pc_i;
  logic [4:0]  rd_i, rd;
  logic [1:0]  wb_sel, mem_width, byte_addr;
  logic        mem_unsigned, reverse_wb, mem, mem_ack, valid_o, stall_i;
  logic [31:0] alu_results, shifter_results, adjacent_pc, data_in;
  logic        dbus_stb, dbus_we, dbus_ack;
  logic [29:0] dbus_adr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_dat_o, dbus_dat_i;
`ifdef FURV_MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  furv_mem #(.DBUS_AW(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_o), .mem_i(mem_i),
    .mem_we_i(mem_we_i), .mem_width_i(mem_width_i), .mem_unsigned_i(mem_unsigned_i),
    .alu_results_i(alu_results_i), .store_data_i(store_data_i),
    .shifter_results_i(shifter_results_i), .adjacent_pc_i(adjacent_pc_i),
    .reverse_wb_i(reverse_wb_i), .wb_sel_i(wb_sel_i), .rd_i(rd_i), .rd(rd),
    .wb_sel(wb_sel), .mem_width(mem_width), .mem_unsigned(mem_unsigned),
    .alu_results(alu_results), .shifter_results(shifter_results),
    .adjacent_pc(adjacent_pc), .reverse_wb(reverse_wb), .mem(mem),
    .byte_addr(byte_addr), .data_in(data_in), .mem_ack(mem_ack), .valid_o(valid_o),
    .stall_i(stall_i), .dbus_stb(dbus_stb), .dbus_we(dbus_we), .dbus_adr(dbus_adr),
    .dbus_sel(dbus_sel), .dbus_dat_o(dbus_dat_o), .dbus_ack(dbus_ack),
    .dbus_dat_i(dbus_dat_i)
`ifdef FURV_MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic is_mem, input logic we, input logic [1:0] w,
                       input logic [31:0] addr, input logic [31:0] d, input logic [4:0] r);
    valid_i       = 1'b1;
    mem_i         = is_mem;
    mem_we_i      = we;
    mem_width_i   = w;
    alu_results_i = addr;
    store_data_i  = d;
    rd_i          = r;
    wb_sel_i      = is_mem ? WB_MEM : WB_ALU;
  endtask

  initial begin
    rst = 1'b1; valid_i = 0; mem_i = 0; mem_we_i = 0; mem_width_i = 0; mem_unsigned_i = 0;
    alu_results_i = 0; store_data_i = 0; shifter_results_i = 0; adjacent_pc_i = 0;
    reverse_wb_i = 0; wb_sel_i = 0; rd_i = 0; stall_i = 0; dbus_ack = 0; dbus_dat_i = 0;
    tick(); tick();
    check("rst_valid", valid_o, 0);
    check("rst_stb", dbus_stb, 0);
    check("rst_we", dbus_we, 0);
    check("rst_rd", rd, 0);
    check("rst_mem_ack", mem_ack, 1);
    check("rst_stall", stall_o, 0);
    rst = 1'b0;
    tick();

    // ALU op passes through with latency 1
    drive(0, 0, MW_WORD, 32'h1234, 0, 5'd5);
    shifter_results_i = 32'h0F0F_0000; adjacent_pc_i = 32'h0000_0104;
    tick();
    check("alu_valid", valid_o, 1);
    check("alu_rd", rd, 5);
    check("alu_res", alu_results, 32'h1234);
    check("alu_pc4", adjacent_pc, 32'h104);
    check("alu_shift", shifter_results, 32'h0F0F_0000);
    check("alu_wbsel", wb_sel, WB_ALU);
    check("alu_stb", dbus_stb, 0);

    // WB stall in IDLE holds everything
    stall_i = 1'b1;
    drive(0, 0, MW_WORD, 32'h9999, 0, 5'd9);
    tick();
    check("stall_rd_hold", rd, 5);
    check("stall_valid_hold", valid_o, 1);
    check("stall_stall_o", stall_o, 1);
    stall_i = 1'b0; valid_i = 1'b0;
    tick();
    check("idle_valid_drop", valid_o, 0);
    check("idle_stb", dbus_stb, 0);

    // sb 0x103
    drive(1, 1, MW_BYTE, 32'h103, 32'h1234_56AB, 5'd0);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("sb_stb", dbus_stb, 1);
      check("sb_we", dbus_we, 1);
      check("sb_adr", dbus_adr, 30'h40);
      check("sb_sel", dbus_sel, 4'b1000);
      check("sb_dat", dbus_dat_o, 32'hABAB_ABAB);
      check("sb_stall", stall_o, 1);
      check("sb_valid", valid_o, 0);
      check("sb_mem_ack", mem_ack, 0);
      tick();
    end
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    check("sb_done_stb", dbus_stb, 0);
    check("sb_done_valid", valid_o, 1);
    check("sb_done_stall", stall_o, 0);
    check("sb_done_mem_ack", mem_ack, 1);

    // sb 0x101 lane
    drive(1, 1, MW_BYTE, 32'h101, 32'h0000_0077, 5'd0);
    tick();
    valid_i = 1'b0;
    check("sb1_sel", dbus_sel, 4'b0010);
    dbus_ack = 1'b1; tick(); dbus_ack = 1'b0;

    // lw 0x200, ack on third BUS cycle
    drive(1, 0, MW_WORD, 32'h200, 32'h0, 5'd7);
    tick();
    valid_i = 1'b0;
    check("lw_we", dbus_we, 0);
    check("lw_sel", dbus_sel, 4'hF);
    check("lw_adr", dbus_adr, 30'h80);
    tick(); tick();
    check("lw_wait_valid", valid_o, 0);
    dbus_ack = 1'b1; dbus_dat_i = 32'hDEAD_BEEF;
    tick();
    dbus_ack = 1'b0; dbus_dat_i = 32'h0;
    check("lw_valid", valid_o, 1);
    check("lw_data", data_in, 32'hDEAD_BEEF);
    check("lw_mem_ack", mem_ack, 1);
    check("lw_rd", rd, 7);

    // lh 0x202 with WB stall during ack
    drive(1, 0, MW_HALF, 32'h202, 32'h0, 5'd3);
    tick();
    valid_i = 1'b0;
    check("lh_sel", dbus_sel, 4'b1100);
    stall_i = 1'b1; dbus_ack = 1'b1; dbus_dat_i = 32'h5555_AAAA;
    tick();
    dbus_ack = 1'b0; dbus_dat_i = 32'h0;
    check("lh_hold_stb", dbus_stb, 0);
    check("lh_hold_valid", valid_o, 0);
    check("lh_hold_mem_ack", mem_ack, 1);
    check("lh_hold_stall", stall_o, 1);
    check("lh_hold_data", data_in, 32'h5555_AAAA);
    tick();
    check("lh_hold2_valid", valid_o, 0);
    stall_i = 1'b0;
    tick();
    check("lh_valid", valid_o, 1);
    check("lh_byte_addr", byte_addr, 2);
    check("lh_stall", stall_o, 0);

    // stray ack in IDLE ignored
    dbus_ack = 1'b1; dbus_dat_i = 32'h1111_2222;
    tick();
    dbus_ack = 1'b0; dbus_dat_i = 32'h0;
    check("stray_data", data_in, 32'h5555_AAAA);
    check("stray_stb", dbus_stb, 0);

    // sh 0x106 lane
    drive(1, 1, MW_HALF, 32'h106, 32'h0000_BEEF, 5'd0);
    tick();
    valid_i = 1'b0;
    check("sh_sel", dbus_sel, 4'b1100);
    check("sh_dat", dbus_dat_o, 32'hBEEF_BEEF);
    dbus_ack = 1'b1; tick(); dbus_ack = 1'b0;

`ifdef FURV_MEM_MISALIGN_TRAP_EN
    drive(1, 0, MW_WORD, 32'h201, 32'h0, 5'd6);
    tick();
    valid_i = 1'b0;
    check("trap_stb", dbus_stb, 0);
    check("trap_valid", valid_o, 1);
    check("trap_flag", misalign_o, 1);
    check("trap_rd", rd, 0);
    check("trap_stall", stall_o, 0);
    tick();
`else
    drive(1, 0, MW_WORD, 32'h201, 32'h0, 5'd6);
    tick();
    valid_i = 1'b0;
    check("mis_stb", dbus_stb, 1);
    check("mis_sel", dbus_sel, 4'hF);
    check("mis_adr", dbus_adr, 30'h80);
    dbus_ack = 1'b1; tick(); dbus_ack = 1'b0;
    check("mis_rd", rd, 6);
`endif

    // reset while in BUS, late ack dropped
    drive(1, 1, MW_WORD, 32'h10, 32'hCAFE_F00D, 5'd1);
    tick();
    valid_i = 1'b0;
    check("rb_stb", dbus_stb, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rb_rst_stb", dbus_stb, 0);
    check("rb_rst_valid", valid_o, 0);
    check("rb_rst_mem_ack", mem_ack, 1);
    dbus_ack = 1'b1; dbus_dat_i = 32'h7777_7777;
    tick();
    dbus_ack = 1'b0;
    check("rb_ack_stb", dbus_stb, 0);
    check("rb_ack_valid", valid_o, 0);
    check("rb_ack_data", data_in, 32'h0);
    check("rb_ack_stall", stall_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
